// File: rtl/csa_multicycle_adder.sv
// Multi-cycle wide adder: streams WIDTH-bit operands through one CHUNK-bit
// conditional-sum adder, one slice per cycle, LSB slice first.

module adder_block #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);
    localparam int LEVELS = $clog2(SIZE);

    logic [SIZE-1:0] gen;
    logic [SIZE-1:0] prop;
    logic [SIZE-1:0] alive;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
            assign gen[gi]   = a[gi] & b[gi];
            assign prop[gi]  = a[gi] ^ b[gi];
            assign alive[gi] = a[gi] | b[gi];
        end
    endgenerate

    // c0/c1 hold the carry out of each bit assuming carry-in 0/1 into its
    // current block; blocks double in size each level, upper halves select
    // between their two precomputed carries using the lower half's carry.
    always_comb begin : p_csum
        logic [SIZE-1:0] c0;
        logic [SIZE-1:0] c1;
        logic [SIZE-1:0] c0n;
        logic [SIZE-1:0] c1n;
        logic [SIZE-1:0] cy;
        int              lo;
        c0  = gen;
        c1  = alive;
        c0n = gen;
        c1n = alive;
        lo  = 0;
        for (int l = 0; l < LEVELS; l++) begin
            c0n = c0;
            c1n = c1;
            for (int i = 0; i < SIZE; i++) begin
                if ((i % (2 << l)) >= (1 << l)) begin
                    lo     = i - (i % (2 << l)) + (1 << l) - 1;
                    c0n[i] = c0[lo] ? c1[i] : c0[i];
                    c1n[i] = c1[lo] ? c1[i] : c0[i];
                end
            end
            c0 = c0n;
            c1 = c1n;
        end
        cy   = cin ? c1 : c0;
        sum  = prop ^ {cy[SIZE-2:0], cin};
        cout = cy[SIZE-1];
    end
endmodule

module csa_multicycle_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSL = 1 << IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 2) begin : g_bad_params
            $error("csa_multicycle_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic [WIDTH-1:0]  sum_next;
    logic              carry_reg;
    logic              cout_reg;
    logic [IW-1:0]     idx_reg;

    logic              accept;
    logic              running;
    logic              last_slice;

    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic [CHUNK-1:0]  a_sl [NSL];
    logic [CHUNK-1:0]  b_sl [NSL];

    // Slice table padded to a power of two so idx_reg indexes it exactly.
    generate
        for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
            if (gi < NCH) begin : g_real
                assign a_sl[gi] = a_reg[gi*CHUNK +: CHUNK];
                assign b_sl[gi] = b_reg[gi*CHUNK +: CHUNK];
                assign sum_next[gi*CHUNK +: CHUNK] =
                    (running && idx_reg == IW'(gi)) ? slice_sum : sum_reg[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign a_sl[gi] = '0;
                assign b_sl[gi] = '0;
            end
        end
    endgenerate

    assign a_slice = a_sl[idx_reg];
    assign b_slice = b_sl[idx_reg];

    adder_block #(
        .SIZE (CHUNK)
    ) u_adder_block (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are masked by rst_n so nothing is offered during reset.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        running    = 1'b0;
        last_slice = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = rst_n;
                accept   = in_valid;
            end
            RUN: begin
                running    = 1'b1;
                last_slice = (idx_reg == LAST_IDX);
            end
            DONE:    out_valid = rst_n;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            sum_reg <= sum_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx_reg   <= '0;
            end
            if (running) begin
                carry_reg <= slice_cout;
                if (last_slice) begin
                    cout_reg <= slice_cout;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
endmodule

// File: tb/tb_csa_multicycle_adder.sv
// Directed and randomized checks of csa_multicycle_adder at 64/16, 32/8 and
// 16/16 configurations sharing one clock and reset.

module tb_csa_multicycle_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        cin_v     [3];
    logic [63:0] a_v       [3];
    logic [63:0] b_v       [3];

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        cout0, cout1, cout2;
    logic [63:0] sum0;
    logic [31:0] sum1;
    logic [15:0] sum2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    csa_multicycle_adder #(.WIDTH(64), .CHUNK(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready0),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .out_valid(out_valid0),
        .out_ready(out_ready[0]), .sum(sum0), .cout(cout0));

    csa_multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready1),
        .a(a_v[1][31:0]), .b(b_v[1][31:0]), .cin(cin_v[1]), .out_valid(out_valid1),
        .out_ready(out_ready[1]), .sum(sum1), .cout(cout1));

    csa_multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready2),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]), .cin(cin_v[2]), .out_valid(out_valid2),
        .out_ready(out_ready[2]), .sum(sum2), .cout(cout2));

    function automatic logic rdy(int k);
        case (k)
            0:       return in_ready0;
            1:       return in_ready1;
            default: return in_ready2;
        endcase
    endfunction

    function automatic logic vld(int k);
        case (k)
            0:       return out_valid0;
            1:       return out_valid1;
            default: return out_valid2;
        endcase
    endfunction

    function automatic logic [64:0] result(int k);
        case (k)
            0:       return {cout0, sum0};
            1:       return {cout1, 32'd0, sum1};
            default: return {cout2, 48'd0, sum2};
        endcase
    endfunction

    function automatic int width_of(int k);
        case (k)
            0:       return 64;
            1:       return 32;
            default: return 16;
        endcase
    endfunction

    function automatic int nch_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    // Reference: plain wide addition, carry taken from bit WIDTH.
    function automatic logic [64:0] model(int k, logic [63:0] a, logic [63:0] b, logic c);
        logic [63:0] mask;
        logic [64:0] full;
        int          w;
        w    = width_of(k);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
        return {full[w], full[63:0] & mask};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction; returns what the DUT produced and how long it took.
    task automatic run_txn(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic c, input int stall,
                           output logic [64:0] res, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (!rdy(k) && n < 50) begin
            tick();
            n++;
        end
        if (!rdy(k)) ok = 1'b0;
        in_valid[k] = 1'b1;
        a_v[k]      = a;
        b_v[k]      = b;
        cin_v[k]    = c;
        tick();
        in_valid[k] = 1'b0;
        a_v[k]      = 'x;
        b_v[k]      = 'x;
        cin_v[k]    = 1'b0;
        lat = 0;
        while (!vld(k) && lat < 50) begin
            tick();
            lat++;
        end
        if (!vld(k)) ok = 1'b0;
        out_ready[k] = 1'b0;
        repeat (stall) tick();
        res          = result(k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            cin_v[k]     = 1'b0;
            a_v[k]       = '0;
            b_v[k]       = '0;
        end
        repeat (3) tick();
        total_cnt++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0)
            $display("FAIL reset_hold: in_ready=%b out_valid=%b, required 0/0", in_ready0, out_valid0);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready0, out_valid0);
        else pass_cnt++;
        total_cnt++;
        if ({cout0, sum0} !== 65'd0)
            $display("FAIL reset_outputs: {cout,sum}=%h, required 0", {cout0, sum0});
        else pass_cnt++;
        total_cnt++;
        if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1)
            $display("FAIL reset_small_cfg: in_ready1=%b in_ready2=%b, required 1/1", in_ready1, in_ready2);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_carry_ripple();
        logic [64:0] res;
        int          lat;
        bit          ok;
        run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== {1'b1, 64'h0})
            $display("FAIL ripple64_result: got %h ok=%0d, required %h", res, ok, {1'b1, 64'h0});
        else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL ripple64_latency: got %0d, required 4", lat);
        else pass_cnt++;
        $display("ripple64 sum=%h lat=%0d", res, lat);

        run_txn(1, 64'hFFFF_FFFF, 64'h0, 1'b1, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== {1'b1, 64'h0} || lat !== 4)
            $display("FAIL ripple32: got %h lat=%0d, required %h lat=4", res, lat, {1'b1, 64'h0});
        else pass_cnt++;
        $display("ripple32 sum=%h lat=%0d", res, lat);

        run_txn(2, 64'hFFFF, 64'h1, 1'b1, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== {1'b1, 64'h1} || lat !== 1)
            $display("FAIL single_slice: got %h lat=%0d, required %h lat=1", res, lat, {1'b1, 64'h1});
        else pass_cnt++;
        $display("single_slice sum=%h lat=%0d", res, lat);
    endtask

    task automatic test_corners();
        logic [64:0] res;
        int          lat;
        bit          ok;
        run_txn(0, 64'h0, 64'h0, 1'b1, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== {1'b0, 64'h1})
            $display("FAIL cin_only: got %h, required %h", res, {1'b0, 64'h1});
        else pass_cnt++;
        $display("cin_only sum=%h", res);
        run_txn(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== {1'b1, 64'h0})
            $display("FAIL msb_pair: got %h, required %h", res, {1'b1, 64'h0});
        else pass_cnt++;
        $display("msb_pair sum=%h", res);
    endtask

    task automatic test_stall();
        int n;
        int lat;
        in_valid[0] = 1'b1;
        a_v[0]      = 64'h0123_4567_89AB_CDEF;
        b_v[0]      = 64'h1111_1111_1111_1111;
        cin_v[0]    = 1'b0;
        tick();
        a_v[0]      = 64'h0000_0000_FFFF_FFFF;
        b_v[0]      = 64'h0000_0000_0000_0001;
        cin_v[0]    = 1'b1;
        n = 0;
        while (!out_valid0 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || {cout0, sum0} !== {1'b0, 64'h1234_5678_9ABC_DF00})
                $display("FAIL stall_hold[%0d]: valid=%b ready=%b {cout,sum}=%h, required 1/0/%h",
                         i, out_valid0, in_ready0, {cout0, sum0}, {1'b0, 64'h1234_5678_9ABC_DF00});
            else pass_cnt++;
            tick();
        end
        out_ready[0] = 1'b1;
        #1;
        total_cnt++;
        if (in_ready0 !== 1'b0)
            $display("FAIL stall_release_ready: in_ready=%b during DONE, required 0", in_ready0);
        else pass_cnt++;
        tick();
        out_ready[0] = 1'b0;
        total_cnt++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0)
            $display("FAIL stall_back_idle: in_ready=%b out_valid=%b, required 1/0", in_ready0, out_valid0);
        else pass_cnt++;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat !== 4 || {cout0, sum0} !== {1'b0, 64'h0000_0001_0000_0001})
            $display("FAIL stall_second: {cout,sum}=%h lat=%0d, required %h lat=4",
                     {cout0, sum0}, lat, {1'b0, 64'h0000_0001_0000_0001});
        else pass_cnt++;
        $display("stall second sum=%h lat=%0d", {cout0, sum0}, lat);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [64:0] res;
        int          lat;
        bit          ok;
        in_valid[0] = 1'b1;
        a_v[0]      = 64'h1111_2222_3333_4444;
        b_v[0]      = 64'h1;
        cin_v[0]    = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || {cout0, sum0} !== 65'd0)
            $display("FAIL midrun_reset: ready=%b valid=%b {cout,sum}=%h, required 1/0/0",
                     in_ready0, out_valid0, {cout0, sum0});
        else pass_cnt++;
        run_txn(0, 64'd5, 64'd7, 1'b1, 0, res, lat, ok);
        total_cnt++;
        if (!ok || res !== 65'd13)
            $display("FAIL midrun_recover: got %h, required %h", res, 65'd13);
        else pass_cnt++;
        $display("midrun recover sum=%h", res);
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp_q[$];
        logic [64:0] exp_v;
        int          nxt, got, cyc, last;
        bit          acc;
        nxt = 0; got = 0; cyc = 0; last = -1;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        a_v[0]  = {32'h9E37_79B9, 32'hFFFF_FFFF};
        b_v[0]  = 64'h0000_0001_0000_0001;
        cin_v[0] = 1'b0;
        while (got < 8 && cyc < 150) begin
            acc = in_ready0 && (nxt < 8);
            if (out_valid0) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_spurious: result %h with nothing outstanding", {cout0, sum0});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({cout0, sum0} !== exp_v)
                        $display("FAIL b2b_result[%0d]: got %h, required %h", got, {cout0, sum0}, exp_v);
                    else pass_cnt++;
                end
                $display("b2b result %0d sum=%h", got, {cout0, sum0});
                got++;
            end
            if (acc) begin
                if (last >= 0) begin
                    total_cnt++;
                    if (cyc - last !== 6)
                        $display("FAIL b2b_period: got %0d cycles, required 6", cyc - last);
                    else pass_cnt++;
                end
                last = cyc;
                exp_q.push_back(model(0, a_v[0], b_v[0], cin_v[0]));
            end
            tick();
            cyc++;
            if (acc) begin
                nxt++;
                if (nxt < 8) begin
                    a_v[0]   = {32'(nxt) * 32'h9E37_79B9, 32'hFFFF_FFFF};
                    b_v[0]   = 64'h0000_0001_0000_0001 << nxt;
                    cin_v[0] = nxt[0];
                end else begin
                    in_valid[0] = 1'b0;
                end
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        total_cnt++;
        if (got !== 8) $display("FAIL b2b_count: got %0d results, required 8", got);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random(input int k, input int count);
        logic [64:0] res;
        logic [64:0] exp_v;
        logic [63:0] a, b;
        logic        c;
        int          lat, bad;
        bit          ok;
        bad = 0;
        for (int i = 0; i < count; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ((i % 17) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
            c = 1'($urandom_range(0, 1));
            run_txn(k, a, b, c, $urandom_range(0, 2), res, lat, ok);
            exp_v = model(k, a, b, c);
            total_cnt++;
            if (!ok || res !== exp_v || lat !== nch_of(k)) begin
                $display("FAIL random_w%0d[%0d]: a=%h b=%h cin=%b got %h lat=%0d, required %h lat=%0d",
                         width_of(k), i, a, b, c, res, lat, exp_v, nch_of(k));
                bad++;
            end else pass_cnt++;
        end
        $display("random width=%0d vectors=%0d errors=%0d", width_of(k), count, bad);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_carry_ripple();
        test_corners();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        test_random(0, 350);
        test_random(1, 350);
        test_random(2, 350);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
